// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;
    localparam int ICACHE_SETS   = 16;
    localparam int ICACHE_WORD_W = 32;
    localparam int IDX_W         = $clog2(ICACHE_SETS);
    localparam int TAG_W         = ICACHE_WORD_W - IDX_W - 2;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_state_t;

    typedef struct packed {
        logic                     valid;
        logic [TAG_W-1:0]         tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

    function automatic logic [IDX_W-1:0] icache_idx(input logic [ICACHE_WORD_W-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] icache_tag(input logic [ICACHE_WORD_W-1:0] addr);
        return addr[ICACHE_WORD_W-1:IDX_W+2];
    endfunction
endpackage

// File: rtl/icache_frames.sv
// Frame storage: combinational read port, synchronous write port, synchronous valid clear.
module icache_frames
    import icache_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IDX_W-1:0]     ridx,
    output icache_frame_t        rframe,
    input  logic                 we,
    input  logic [IDX_W-1:0]     widx,
    input  icache_frame_t        wframe
);
    logic [SETS-1:0]                 valid;
    logic [TAG_W-1:0]                tags  [SETS];
    logic [ICACHE_WORD_W-1:0]        datas [SETS];

    always_ff @(posedge CLK) begin
        if (RST)
            valid <= '0;
        else if (we)
            valid[widx] <= wframe.valid;
    end

    // Tag/data carry no reset; a reset-cycle write is dropped so nothing stale is kept.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            tags[widx]  <= wframe.tag;
            datas[widx] <= wframe.data;
        end
    end

    always_comb begin
        rframe       = '0;
        rframe.valid = valid[ridx];
        rframe.tag   = tags[ridx];
        rframe.data  = datas[ridx];
    end
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word fill FSM, perf counters.
module icache_direct
    import icache_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int WORD_W = ICACHE_WORD_W,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    input  logic              halt,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    icache_state_t     state, state_nxt;
    logic [WORD_W-1:0] miss_addr;
    icache_frame_t     rframe, wframe;
    logic              we, miss_start, lookup_hit;

    icache_frames #(.SETS(SETS)) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .ridx   (icache_idx(imemaddr)),
        .rframe (rframe),
        .we     (we),
        .widx   (icache_idx(miss_addr)),
        .wframe (wframe)
    );

    assign lookup_hit = rframe.valid && (rframe.tag == icache_tag(imemaddr));

    always_comb begin
        wframe       = '0;
        wframe.valid = 1'b1;
        wframe.tag   = icache_tag(miss_addr);
        wframe.data  = iload;
    end

    // Outputs are gated by RST so the reset cycle itself is quiet.
    always_comb begin
        state_nxt  = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        we         = 1'b0;
        miss_start = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (imemREN) begin
                        if (lookup_hit) begin
                            ihit     = 1'b1;
                            imemload = rframe.data;
                        end else begin
                            miss_start = 1'b1;
                            state_nxt  = FILL;
                        end
                    end
                end
                FILL: begin
                    // Fill always targets miss_addr; redirects wait until IDLE.
                    iREN  = 1'b1;
                    iaddr = miss_addr;
                    if (!iwait) begin
                        we        = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start)
                miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
            if (!halt) begin
                if (ihit)
                    hit_count <= hit_count + 1'b1;
                if (miss_start)
                    miss_count <= miss_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized traffic vs a frame-array model.
module tb_icache_direct;
    logic        CLK = 1'b0;
    logic        RST, imemREN, iwait, halt;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    // Reference model: what each frame should hold, and the counter values.
    bit          mv [16];
    logic [25:0] mt [16];
    logic [31:0] md [16];
    logic [31:0] mhit, mmiss;

    icache_direct dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .halt(halt),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return mv[a[5:2]] && (mt[a[5:2]] == a[31:6]);
    endfunction

    task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
        mv[a[5:2]] = 1'b1;
        mt[a[5:2]] = a[31:6];
        md[a[5:2]] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        mhit  = 0;
        mmiss = 0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input logic rst, input logic hl, input logic ren,
                         input logic [31:0] a, input logic wt, input logic [31:0] ld);
        @(negedge CLK);
        RST = rst; halt = hl; imemREN = ren; imemaddr = a; iwait = wt; iload = ld;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 32'h0, 1, 32'h0);
        drive(1, 0, 1, 32'h0, 0, 32'hFFFF_FFFF);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h want 0/0/0/0", ihit, iREN, iaddr, imemload);
        end
        m_clear();
        drive(0, 0, 0, 32'h0, 1, 32'h0);
        checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0 || ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hits=%0d misses=%0d ihit=%b iREN=%b want 0/0/0/0", hit_count, miss_count, ihit, iREN);
        end
    endtask

    task automatic test_cold_miss();
        drive(0, 0, 1, 32'h0, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL cold_lookup: ihit=%b iREN=%b want 0/0", ihit, iREN);
        end
        mmiss++;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 1, 32'h0, (c != 3), (c == 3) ? 32'h2001_0004 : 32'h0);
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0) begin
                errors++;
                $display("FAIL cold_fill c%0d: iREN=%b iaddr=%h ihit=%b want 1/00000000/0", c, iREN, iaddr, ihit);
            end
        end
        m_fill(32'h0, 32'h2001_0004);
        drive(0, 0, 1, 32'h0, 1, 32'h0);
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h2001_0004 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL cold_refetch: ihit=%b imemload=%h misses=%0d want 1/20010004/1", ihit, imemload, miss_count);
        end
        mhit++;
    endtask

    task automatic test_repeat_hit();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 1, 32'h0, 1, 32'h0);
            checks++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== 32'h2001_0004 || hit_count !== mhit) begin
                errors++;
                $display("FAIL repeat_hit c%0d: ihit=%b iREN=%b load=%h hits=%0d want 1/0/20010004/%0d", c, ihit, iREN, imemload, hit_count, mhit);
            end
            mhit++;
        end
        drive(0, 0, 0, 32'h0, 1, 32'h0);
        checks++;
        if (hit_count !== 32'd6 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL repeat_count: hits=%0d ihit=%b want 6/0", hit_count, ihit);
        end
    endtask

    task automatic test_conflict();
        drive(0, 0, 1, 32'h40, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL conflict_miss40: ihit=%b want 0", ihit);
        end
        mmiss++;
        drive(0, 0, 1, 32'h40, 0, memword(32'h40));
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h40) begin
            errors++;
            $display("FAIL conflict_fill40: iREN=%b iaddr=%h want 1/00000040", iREN, iaddr);
        end
        m_fill(32'h40, memword(32'h40));
        drive(0, 0, 1, 32'h40, 1, 32'h0);
        checks++;
        if (ihit !== 1'b1 || imemload !== memword(32'h40)) begin
            errors++;
            $display("FAIL conflict_hit40: ihit=%b load=%h want 1/%h", ihit, imemload, memword(32'h40));
        end
        mhit++;
        drive(0, 0, 1, 32'h0, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL conflict_evicted: ihit=%b load=%h want 0/0", ihit, imemload);
        end
        mmiss++;
        drive(0, 0, 1, 32'h0, 0, 32'h2001_0004);
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h0 || miss_count !== mmiss) begin
            errors++;
            $display("FAIL conflict_refill: iREN=%b iaddr=%h misses=%0d want 1/0/%0d", iREN, iaddr, miss_count, mmiss);
        end
        m_fill(32'h0, 32'h2001_0004);
    endtask

    task automatic test_redirect();
        drive(0, 0, 1, 32'h8, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL redir_miss8: ihit=%b iREN=%b want 0/0", ihit, iREN);
        end
        mmiss++;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 1, 32'h100, (c != 2), memword(32'h8));
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h8 || ihit !== 1'b0) begin
                errors++;
                $display("FAIL redir_fill c%0d: iREN=%b iaddr=%h ihit=%b want 1/00000008/0", c, iREN, iaddr, ihit);
            end
        end
        m_fill(32'h8, memword(32'h8));
        drive(0, 0, 1, 32'h100, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL redir_miss100: ihit=%b iREN=%b want 0/0", ihit, iREN);
        end
        mmiss++;
        drive(0, 0, 1, 32'h100, 0, memword(32'h100));
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h100) begin
            errors++;
            $display("FAIL redir_fill100: iREN=%b iaddr=%h want 1/00000100", iREN, iaddr);
        end
        m_fill(32'h100, memword(32'h100));
        drive(0, 0, 1, 32'h8, 1, 32'h0);
        checks++;
        if (ihit !== 1'b1 || imemload !== memword(32'h8) || miss_count !== mmiss) begin
            errors++;
            $display("FAIL redir_frame2: ihit=%b load=%h misses=%0d want 1/%h/%0d", ihit, imemload, miss_count, memword(32'h8), mmiss);
        end
        mhit++;
    endtask

    task automatic test_reset_midfill();
        drive(0, 0, 1, 32'h44, 1, 32'h0);
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL midrst_miss: ihit=%b want 0", ihit);
        end
        drive(0, 0, 1, 32'h44, 1, 32'h0);
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            errors++;
            $display("FAIL midrst_fill1: iREN=%b iaddr=%h want 1/00000044", iREN, iaddr);
        end
        // Reset coincides with the memory returning data: the frame must stay empty.
        drive(1, 0, 1, 32'h44, 0, 32'hDEAD_BEEF);
        m_clear();
        drive(0, 0, 1, 32'h44, 1, 32'h0);
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL midrst_after: iREN=%b ihit=%b hits=%0d misses=%0d want 0/0/0/0", iREN, ihit, hit_count, miss_count);
        end
        mmiss++;
        drive(0, 0, 1, 32'h44, 0, memword(32'h44));
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            errors++;
            $display("FAIL midrst_refill: iREN=%b iaddr=%h want 1/00000044", iREN, iaddr);
        end
        m_fill(32'h44, memword(32'h44));
        drive(0, 0, 1, 32'h44, 1, 32'h0);
        checks++;
        if (ihit !== 1'b1 || imemload !== memword(32'h44) || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL midrst_hit: ihit=%b load=%h misses=%0d want 1/%h/1", ihit, imemload, miss_count, memword(32'h44));
        end
        mhit++;
    endtask

    task automatic test_halt();
        drive(0, 0, 1, 32'h0, 1, 32'h0);
        mmiss++;
        drive(0, 0, 1, 32'h0, 0, 32'h2001_0004);
        m_fill(32'h0, 32'h2001_0004);
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 1, 32'h0, 1, 32'h0);
            checks++;
            if (ihit !== 1'b1 || hit_count !== mhit || miss_count !== mmiss) begin
                errors++;
                $display("FAIL halt_hit c%0d: ihit=%b hits=%0d misses=%0d want 1/%0d/%0d", c, ihit, hit_count, miss_count, mhit, mmiss);
            end
        end
        drive(0, 1, 1, 32'h4, 1, 32'h0);
        drive(0, 1, 1, 32'h4, 0, memword(32'h4));
        m_fill(32'h4, memword(32'h4));
        drive(0, 0, 1, 32'h4, 1, 32'h0);
        checks++;
        if (ihit !== 1'b1 || hit_count !== mhit || miss_count !== mmiss) begin
            errors++;
            $display("FAIL halt_frozen: ihit=%b hits=%0d misses=%0d want 1/%0d/%0d", ihit, hit_count, miss_count, mhit, mmiss);
        end
        mhit++;
    endtask

    task automatic test_random();
        logic [31:0] a, ra, ma, exp_ld;
        bit          ren, hl, eh, fail;
        int          wt;
        int          nfail = 0;
        for (int n = 0; n < 400; n++) begin
            a   = 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            ren = ($urandom_range(0, 4) != 0);
            hl  = ($urandom_range(0, 7) == 0);
            drive(0, hl, ren, a, 1'b1, 32'h0);
            eh     = ren && m_hit(a);
            exp_ld = eh ? md[a[5:2]] : 32'h0;
            checks++;
            if (ihit !== eh || imemload !== exp_ld || iREN !== 1'b0 || iaddr !== 32'h0
                || hit_count !== mhit || miss_count !== mmiss) begin
                errors++;
                nfail++;
                if (nfail < 10)
                    $display("FAIL rnd_lookup a=%h: ihit=%b load=%h iREN=%b hits=%0d misses=%0d want %b/%h/0/%0d/%0d",
                             a, ihit, imemload, iREN, hit_count, miss_count, eh, exp_ld, mhit, mmiss);
            end
            if (!hl) begin
                if (eh) mhit++;
                else if (ren) mmiss++;
            end
            if (ren && !eh) begin
                wt = $urandom_range(0, 3);
                ma = {a[31:2], 2'b00};
                for (int w = 0; w <= wt; w++) begin
                    ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : a;
                    drive(0, hl, 1'($urandom_range(0, 1)), ra, (w != wt), memword(ma));
                    checks++;
                    fail = (iREN !== 1'b1 || iaddr !== ma || ihit !== 1'b0 || imemload !== 32'h0
                            || hit_count !== mhit || miss_count !== mmiss);
                    if (fail) begin
                        errors++;
                        nfail++;
                        if (nfail < 10)
                            $display("FAIL rnd_fill ma=%h w%0d: iREN=%b iaddr=%h ihit=%b hits=%0d misses=%0d want 1/%h/0/%0d/%0d",
                                     ma, w, iREN, iaddr, ihit, hit_count, miss_count, ma, mhit, mmiss);
                    end
                end
                m_fill(ma, memword(ma));
            end
        end
    endtask

    initial begin
        RST = 1'b1; halt = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        mhit = 0; mmiss = 0;
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_redirect();
        test_reset_midfill();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
